// File: rtl/adc_ltc2308_seq_if.sv
// Sample stream leaving the LTC2308 scan sequencer: one tagged 12-bit result per transfer.
// A transfer happens on a clk edge where sample_valid && sample_ready; the producer holds
// data/ch stable while valid is high and not accepted, and never drops valid without a transfer.
interface adc_ltc2308_seq_if;
    logic [11:0] sample_data;
    logic [2:0]  sample_ch;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output sample_data,
        output sample_ch,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_ch,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/adc_ltc2308_seq.sv
// Autonomous round-robin scan sequencer for the LTC2308 8-channel 12-bit SPI ADC.
// Each frame: CONVST pulse, 12 SCK periods (config word out, result in), acquisition gap.
module adc_ltc2308_seq #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80,
    parameter int ACQ_CYCLES  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [2:0]               ch_last,
    input  logic                     uni,
    output logic                     adc_convst,
    output logic                     adc_sck,
    output logic                     adc_sdi,
    input  logic                     adc_sdo,
    adc_ltc2308_seq_if.master        smp,
    output logic                     overrun,
    input  logic                     overrun_clr,
    output logic                     busy,
    output logic [1:0]               state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        ACQ   = 2'd3
    } state_t;

    localparam int CW = 16;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    bit_cnt, bit_cnt_nx;
    logic          sck_nx, convst_nx, sdi_nx;
    logic          frame_start, frame_end, sck_rise;

    logic [2:0]    cur_ch, cfg_ch, prev_ch, ch_next;
    logic          cfg_uni, primed;
    logic [11:0]   shreg;
    logic [5:0]    word;
    logic          accept, deliver, load_smp, drop_smp;

    // LTC2308 DIN word: S/D, O/S, S1, S0, UNI, SLP; O/S carries the channel LSB.
    assign word      = {1'b1, cfg_ch[0], cfg_ch[2], cfg_ch[1], cfg_uni, 1'b0};
    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign ch_next   = (cur_ch >= ch_last) ? 3'd0 : cur_ch + 3'd1;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt + CW'(1);
        bit_cnt_nx  = bit_cnt;
        sck_nx      = adc_sck;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        sck_rise    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (enable) begin
                    state_nx    = CONV;
                    frame_start = 1'b1;
                end
            end
            CONV: begin
                if (cnt == CW'(CONV_CYCLES - 1)) begin
                    state_nx   = SHIFT;
                    cnt_nx     = '0;
                    bit_cnt_nx = '0;
                    sck_nx     = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt == CW'(CLK_DIV - 1)) begin
                    cnt_nx = '0;
                    sck_nx = ~adc_sck;
                    if (!adc_sck) begin
                        sck_rise = 1'b1;
                    end else begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd11) begin
                            state_nx  = ACQ;
                            frame_end = 1'b1;
                        end
                    end
                end
            end
            ACQ: begin
                if (cnt == CW'(ACQ_CYCLES - 1)) begin
                    cnt_nx = '0;
                    if (enable) begin
                        state_nx    = CONV;
                        frame_start = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        convst_nx = (state_nx == CONV);
        // SDI leads each SCK period: set on SHIFT entry and on every falling edge.
        sdi_nx = 1'b0;
        if (state_nx == SHIFT && bit_cnt_nx < 4'd6) begin
            sdi_nx = word[3'd5 - bit_cnt_nx[2:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            adc_convst <= 1'b0;
            adc_sck    <= 1'b0;
            adc_sdi    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            bit_cnt    <= bit_cnt_nx;
            adc_convst <= convst_nx;
            adc_sck    <= sck_nx;
            adc_sdi    <= sdi_nx;
        end
    end

    assign accept   = smp.sample_valid & smp.sample_ready;
    assign deliver  = frame_end & primed;
    assign load_smp = deliver & (~smp.sample_valid | accept);
    assign drop_smp = deliver & smp.sample_valid & ~accept;

    // The result shifted out in a frame belongs to the channel configured one frame earlier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_ch           <= '0;
            cfg_ch           <= '0;
            prev_ch          <= '0;
            cfg_uni          <= 1'b0;
            primed           <= 1'b0;
            shreg            <= '0;
            smp.sample_data  <= '0;
            smp.sample_ch    <= '0;
            smp.sample_valid <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            if (frame_start) begin
                cfg_ch  <= cur_ch;
                cfg_uni <= uni;
            end
            if (sck_rise) begin
                shreg <= {shreg[10:0], adc_sdo};
            end
            if (frame_end) begin
                prev_ch <= cfg_ch;
                cur_ch  <= ch_next;
            end
            if (state == ACQ && state_nx == IDLE) begin
                primed <= 1'b0;
            end else if (frame_end) begin
                primed <= 1'b1;
            end
            if (load_smp) begin
                smp.sample_data  <= shreg;
                smp.sample_ch    <= prev_ch;
                smp.sample_valid <= 1'b1;
            end else if (accept) begin
                smp.sample_valid <= 1'b0;
            end
            if (drop_smp) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_ltc2308_seq.sv
// Directed bench for adc_ltc2308_seq with a behavioural LTC2308 model and a sample scoreboard.
module tb_adc_ltc2308_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  ch_last = 3'd0;
    logic        uni = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        adc_convst, adc_sck, adc_sdi, adc_sdo;
    logic        overrun, busy;
    logic [1:0]  state_dbg;
    int          cyc = 0;

    adc_ltc2308_seq_if smp ();

    adc_ltc2308_seq dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .ch_last     (ch_last),
        .uni         (uni),
        .adc_convst  (adc_convst),
        .adc_sck     (adc_sck),
        .adc_sdi     (adc_sdi),
        .adc_sdo     (adc_sdo),
        .smp         (smp),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- ADC model ----------------
    logic [11:0] adc_tbl [8];
    logic [11:0] adc_out = '0;
    logic [11:0] adc_in = '0;
    logic [2:0]  adc_sel = '0;
    int          adc_bits = 0;
    logic        m_conv_d = 1'b0;
    logic        m_sck_d = 1'b0;
    logic [11:0] sdi_q[$];

    assign adc_sdo = adc_out[11];

    always @(adc_convst or adc_sck) begin
        if (adc_convst && !m_conv_d) begin
            adc_out  = adc_tbl[adc_sel];
            adc_bits = 0;
        end
        if (adc_sck && !m_sck_d) begin
            adc_in = {adc_in[10:0], adc_sdi};
            adc_bits++;
            if (adc_bits == 12) begin
                sdi_q.push_back(adc_in);
                adc_sel = {adc_in[9], adc_in[8], adc_in[10]};
            end
        end
        if (!adc_sck && m_sck_d) adc_out = {adc_out[10:0], 1'b0};
        m_conv_d = adc_convst;
        m_sck_d  = adc_sck;
    end

    // ---------------- monitors ----------------
    logic [14:0] got_q[$];
    int          got_cyc_q[$];
    int          vrise_q[$];
    int          conv_len_q[$];
    int          pulse_q[$];
    logic        mv_d = 1'b0, mc_d = 1'b0, ms_d = 1'b0;
    int          conv_run = 0, rise_cnt = 0, last_rise = 0;
    logic        per_bad = 1'b0;

    always @(negedge clk) begin
        if (smp.sample_valid && smp.sample_ready) begin
            got_q.push_back({smp.sample_ch, smp.sample_data});
            got_cyc_q.push_back(cyc);
        end
        if (smp.sample_valid && !mv_d) vrise_q.push_back(cyc);
        mv_d = smp.sample_valid;
        if (adc_convst) conv_run++;
        else if (conv_run != 0) begin
            conv_len_q.push_back(conv_run);
            conv_run = 0;
        end
        if (adc_convst && !mc_d) begin
            if (rise_cnt != 0) pulse_q.push_back(rise_cnt);
            rise_cnt = 0;
        end
        mc_d = adc_convst;
        if (adc_sck && !ms_d) begin
            if (rise_cnt != 0 && cyc - last_rise != 4) per_bad = 1'b1;
            rise_cnt++;
            last_rise = cyc;
        end
        ms_d = adc_sck;
    end

    // ---------------- scoreboard / checking ----------------
    logic [14:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        smp.sample_ready = 1'b0;
        overrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_samples(input int n, input int budget);
        int t = 0;
        while (got_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (got_q.size() < n) check_eq("sample_timeout", 32'(got_q.size()), 32'(n));
    endtask

    task automatic wait_valid(input int budget, output int c);
        int t = 0;
        while (!smp.sample_valid && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (!smp.sample_valid) check_eq("valid_timeout", 0, 1);
        c = cyc;
    endtask

    task automatic wait_until_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_convst"}, 32'(adc_convst), 0);
        check_eq({tag, "_sck"}, 32'(adc_sck), 0);
        check_eq({tag, "_sdi"}, 32'(adc_sdi), 0);
        check_eq({tag, "_valid"}, 32'(smp.sample_valid), 0);
        check_eq({tag, "_data"}, 32'(smp.sample_data), 0);
        check_eq({tag, "_ch"}, 32'(smp.sample_ch), 0);
        check_eq({tag, "_overrun"}, 32'(overrun), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_state"}, 32'(state_dbg), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gb, sb, vb, cb, pb, en_cyc, c_v, t;
        logic [11:0] exp_sdi [5];

        adc_tbl[0] = 12'hA5C; adc_tbl[1] = 12'h3F1; adc_tbl[2] = 12'h7E2; adc_tbl[3] = 12'h5A3;
        adc_tbl[4] = 12'h104; adc_tbl[5] = 12'h205; adc_tbl[6] = 12'h306; adc_tbl[7] = 12'hF07;
        smp.sample_ready = 1'b0;

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Scan 0..7 with uni=1, then lower ch_last to 0 while channel 2 is configured.
        ch_last = 3'd7; uni = 1'b1; smp.sample_ready = 1'b1;
        gb = got_q.size(); sb = sdi_q.size(); vb = vrise_q.size();
        cb = conv_len_q.size(); pb = pulse_q.size();
        en_cyc = cyc;
        enable = 1'b1;
        wait_samples(gb + 1, 400);
        ch_last = 3'd0;
        check_eq("first_latency", 32'(vrise_q[vb] - en_cyc), 273);
        check_eq("no_valid_frame1", 32'(vrise_q[vb] - en_cyc > 145), 1);
        wait_samples(gb + 4, 700);
        exp_q.push_back({3'd0, 12'hA5C}); exp_q.push_back({3'd1, 12'h3F1});
        exp_q.push_back({3'd2, 12'h7E2}); exp_q.push_back({3'd0, 12'hA5C});
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("scan7_s%0d", i), 32'(got_q[gb + i]), 32'(exp_q.pop_front()));
        check_eq("sample_spacing", 32'(got_cyc_q[gb + 1] - got_cyc_q[gb]), 144);
        check_eq("convst_len", 32'(conv_len_q[cb]), 80);
        check_eq("sck_pulses", 32'(pulse_q[pb]), 12);
        check_eq("sck_period_bad", 32'(per_bad), 0);
        exp_sdi[0] = 12'h880; exp_sdi[1] = 12'hC80; exp_sdi[2] = 12'h980;
        exp_sdi[3] = 12'h880; exp_sdi[4] = 12'h880;
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("sdi_word%0d", i), 32'(sdi_q[sb + i]), 32'(exp_sdi[i]));

        // ch_last=2: tags 0,1,2,0,1.
        do_reset();
        ch_last = 3'd2; uni = 1'b1; smp.sample_ready = 1'b1;
        gb = got_q.size();
        enable = 1'b1;
        wait_samples(gb + 5, 1000);
        exp_q.push_back({3'd0, 12'hA5C}); exp_q.push_back({3'd1, 12'h3F1});
        exp_q.push_back({3'd2, 12'h7E2}); exp_q.push_back({3'd0, 12'hA5C});
        exp_q.push_back({3'd1, 12'h3F1});
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("scan2_s%0d", i), 32'(got_q[gb + i]), 32'(exp_q.pop_front()));

        // Backpressure: hold first sample, overrun, clear, set-wins-over-clear.
        do_reset();
        ch_last = 3'd7; uni = 1'b1;
        enable = 1'b1;
        wait_valid(400, c_v);
        check_eq("bp_first_ovr", 32'(overrun), 0);
        check_eq("bp_first_data", 32'(smp.sample_data), 'hA5C);
        wait_until_cyc(c_v + 150);
        check_eq("bp_ovr_set", 32'(overrun), 1);
        check_eq("bp_held_data", 32'(smp.sample_data), 'hA5C);
        check_eq("bp_held_ch", 32'(smp.sample_ch), 0);
        check_eq("bp_held_valid", 32'(smp.sample_valid), 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check_eq("bp_ovr_clr", 32'(overrun), 0);
        wait_until_cyc(c_v + 287);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check_eq("bp_set_wins", 32'(overrun), 1);
        check_eq("bp_held_data2", 32'(smp.sample_data), 'hA5C);
        gb = got_q.size();
        @(posedge clk);
        #1 smp.sample_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_drain_valid", 32'(smp.sample_valid), 0);
        check_eq("bp_drain_sample", 32'(got_q[gb]), 32'({3'd0, 12'hA5C}));

        // enable dropped mid-SHIFT of frame 3.
        do_reset();
        ch_last = 3'd7; uni = 1'b1; smp.sample_ready = 1'b1;
        gb = got_q.size();
        enable = 1'b1;
        wait_valid(400, c_v);
        wait_until_cyc(c_v + 110);
        check_eq("drop_in_shift", 32'(state_dbg), 2);
        enable = 1'b0;
        wait_until_cyc(c_v + 150);
        check_eq("drop_busy_acq", 32'(busy), 1);
        check_eq("drop_sample_cnt", 32'(got_q.size() - gb), 2);
        check_eq("drop_sample", 32'(got_q[gb + 1]), 32'({3'd1, 12'h3F1}));
        wait_until_cyc(c_v + 161);
        check_eq("drop_busy_idle", 32'(busy), 0);
        check_eq("drop_convst", 32'(adc_convst), 0);
        check_eq("drop_sck", 32'(adc_sck), 0);
        vb = vrise_q.size();
        en_cyc = cyc;
        enable = 1'b1;
        wait_samples(gb + 3, 400);
        check_eq("reen_latency", 32'(vrise_q[vb] - en_cyc), 273);
        check_eq("reen_sample", 32'(got_q[gb + 2]), 32'({3'd3, 12'h5A3}));

        // rst while SCK high mid-SHIFT, then a bipolar frame.
        do_reset();
        ch_last = 3'd7; uni = 1'b1; smp.sample_ready = 1'b1;
        enable = 1'b1;
        t = 0;
        while (!(state_dbg == 2'd2 && adc_sck) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_eq("rst_reached_sck_hi", 32'(adc_sck), 1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        uni = 1'b0;
        sb = sdi_q.size();
        rst = 1'b0;
        t = 0;
        while (sdi_q.size() <= sb && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_eq("bipolar_word", 32'(sdi_q[sb]), 'h800);

        enable = 1'b0;
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_ltc2308_seq.md
Name: adc_ltc2308_seq

Overview:
- Autonomous scan sequencer for the board's LTC2308 8-channel 12-bit SPI ADC (pins ADC_CONVST/ADC_SCK/ADC_SDI/ADC_SDO).
- Round-robins single-ended channels 0..ch_last and presents each result as a tagged sample on a valid/ready stream.
- Sits directly upstream of the soc_system input PIO/FIFO bridge that exposes samples to HPS/Nios; runs in the FPGA_CLK1_50 domain.

Parameters:
CLK_DIV, 2, SCK half-period in clk cycles (>=2); SCK = clk/(2*CLK_DIV), 12.5 MHz at 50 MHz
CONV_CYCLES, 80, clk cycles CONVST held high for conversion (>= tCONV 1.6 us)
ACQ_CYCLES, 16, clk cycles idle between end of shift and next CONVST (>= tACQ 240 ns)

Ports:
clk  in  1  system clock (FPGA_CLK1_50)
rst  in  1  asynchronous, active-high reset
enable  in  1  1 = scan continuously; 0 = stop after current frame
ch_last  in  3  last channel of scan; sequence 0..ch_last, wraps to 0
uni  in  1  1 = unipolar (0..4.096 V), 0 = bipolar; sampled at frame start
adc_convst  out  1  to ADC_CONVST
adc_sck  out  1  to ADC_SCK, idle low
adc_sdi  out  1  to ADC_SDI, config word MSB first
adc_sdo  in  1  from ADC_SDO
sample_data  out  12  conversion result, straight binary / two's complement as per uni
sample_ch  out  3  channel that sample_data belongs to
sample_valid  out  1  output holding register full
sample_ready  in  1  consumer accepts when valid&ready at clk edge
overrun  out  1  sticky: sample dropped because holding register full
overrun_clr  in  1  clears overrun (set wins if same cycle)
busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset: all outputs 0; state IDLE; cur_ch=0; primed=0.
- FSM: IDLE -> CONV -> SHIFT -> ACQ -> (CONV if enable else IDLE).
- IDLE: enable=1 -> CONV next cycle; latch cfg_ch=cur_ch, cfg_uni=uni.
- CONV: adc_convst=1 for exactly CONV_CYCLES cycles, then 0 on entering SHIFT.
- SHIFT: 12 SCK periods, each CLK_DIV low then CLK_DIV high, ends low. adc_sdi presents 6-bit word {1, cfg_ch[0], cfg_ch[2], cfg_ch[1], cfg_uni, 0} MSB first, valid from SHIFT entry and updated on each SCK falling edge; after 6 bits adc_sdi=0. adc_sdo sampled on the clk cycle where adc_sck goes 0->1, shifted MSB first into 12-bit register.
- ACQ: ACQ_CYCLES cycles, convst=0, sck=0.
- Pipeline: the word sent in frame N selects frame N+1's conversion. Track prev_ch. First frame after leaving IDLE produces no sample (primed=0 -> set 1). Later frames: at SHIFT->ACQ, result tagged with prev_ch.
- Channel advance at each frame end: cur_ch = (cur_ch==ch_last) ? 0 : cur_ch+1; if ch_last lowered below cur_ch, next = 0.
- Output: holding register loaded at SHIFT->ACQ when empty, or when emptied that same cycle (valid&ready); sample_valid then 1. If full and not accepted: sample dropped, overrun=1, old sample retained.
- sample_data/sample_ch stable while sample_valid=1 and not accepted.
- enable fall mid-frame: frame completes incl. sample delivery, then IDLE; primed cleared on IDLE entry.
- Frame period = CONV_CYCLES + 24*CLK_DIV + ACQ_CYCLES (144 cycles at defaults).
- rst mid-frame: immediate return to reset values (convst, sck low); partial data discarded.

Test Plan:
- Reset then enable=1, ch_last=7, uni=1, ADC model: convst high 80 cycles, 12 sck pulses of 4-cycle period, SDI words 0x22(ch0),0x32(ch1)... (bits 100010, 110010); no sample_valid in first frame.
- ADC model returns 0xA5C for ch0, 0x3F1 for ch1 -> samples {ch0,0xA5C} after frame 2, {ch1,0x3F1} after frame 3, 144 cycles apart, sample_ready=1.
- ch_last=2 -> sample_ch sequence 0,1,2,0,1; change ch_last to 0 while cur_ch=2 -> next configured channel 0.
- sample_ready=0 for 3 frames -> first sample held unchanged, overrun=1 after frame 2 delivery; overrun_clr pulse -> 0; simultaneous overrun event and clr -> 1.
- enable dropped mid-SHIFT -> frame finishes, sample delivered, busy=0, convst=0; re-enable -> first frame discarded again.
- rst asserted mid-SHIFT at sck=1 -> next clk all outputs 0, state IDLE; uni=0 frame sends word bit UNI=0 (0x20 for ch0).
